// File: rtl/counter_pkg.sv
// Shared types and limits for the parametrised up/down modulo counter.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } mode_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: tick is high on every PRESCALE-th enabled cycle; restart returns to phase 0.
// Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q, phase_d;

    // With PRESCALE=1, LAST is 0 and the phase never leaves 0, so tick stays high.
    assign tick = (phase_q == LAST);

    always_comb begin
        phase_d = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = tick ? '0 : phase_q + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with wrap/saturate mode, clamp-on-load and wrap pulse.
// Optional enable prescaler is built in when COUNTER_PRESCALE_EN is defined.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter mode_e           MODE  = MODE_WRAP
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int unsigned     PRESCALE = 4
`endif
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be in 2..32");
    end
    if (MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("counter_updown_mod: MAX exceeds 2**WIDTH-1");
    end
`ifdef COUNTER_PRESCALE_EN
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_updown_mod: PRESCALE must be >= 1");
    end
`endif

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             tick;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK     (CLK),
        .reset   (reset),
        .en      (en),
        .restart (clr | load),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en && tick) begin
            if (up_dn) begin
                if (count_q != MAX_V) begin
                    count_d = count_q + WIDTH'(1);
                end else if (MODE == MODE_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (MODE == MODE_WRAP) begin
                    count_d = MAX_V;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = up_dn ? (count_q == MAX_V) : (count_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: a WRAP and a SAT instance (WIDTH=4, MAX=11) share one stimulus stream.
module tb_counter_updown_mod;
    import counter_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] count_w, count_s;
    logic       tc_w, tc_s, wrap_w, wrap_s;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    counter_updown_mod #(
        .WIDTH (4),
        .MAX   (11),
        .MODE  (MODE_WRAP)
    ) u_dut_wrap (
        .CLK      (CLK),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count_w),
        .tc       (tc_w),
        .wrap     (wrap_w)
    );

    counter_updown_mod #(
        .WIDTH (4),
        .MAX   (11),
        .MODE  (MODE_SAT)
    ) u_dut_sat (
        .CLK      (CLK),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count_s),
        .tc       (tc_s),
        .wrap     (wrap_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs change only here, well away from the next edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic both(input string tag, input int cw, input int cs,
                        input logic tw, input logic ts, input logic ww, input logic ws);
        check({tag, " wrap.count"}, 32'(count_w), 32'(cw));
        check({tag, " sat.count"}, 32'(count_s), 32'(cs));
        check({tag, " wrap.tc"}, 32'(tc_w), 32'(tw));
        check({tag, " sat.tc"}, 32'(tc_s), 32'(ts));
        check({tag, " wrap.wrap"}, 32'(wrap_w), 32'(ww));
        check({tag, " sat.wrap"}, 32'(wrap_s), 32'(ws));
    endtask

    initial begin
        #2;
        both("reset", 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        step();
        both("idle", 0, 0, 0, 0, 0, 0);

        // Reach 7 mid-count, then async reset between edges.
        load = 1'b1; load_val = 4'd6; step();
        load = 1'b0; en = 1'b1; step();
        both("pre-reset", 7, 7, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1 both("async reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(); both("after reset 1", 1, 1, 0, 0, 0, 0);
        step(); both("after reset 2", 2, 2, 0, 0, 0, 0);
        step(); both("after reset 3", 3, 3, 0, 0, 0, 0);

        // Up from 10: WRAP 10,11,0,1; SAT holds 11 for 5 cycles.
        en = 1'b0; load = 1'b1; load_val = 4'd10; step();
        both("up load10", 10, 10, 0, 0, 0, 0);
        load = 1'b0; en = 1'b1; step();
        both("up 11", 11, 11, 1, 1, 0, 0);
        step(); both("up roll", 0, 11, 0, 1, 1, 0);
        step(); both("up 1", 1, 11, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat hold up count", 32'(count_s), 32'd11);
            check("sat hold up wrap", 32'(wrap_s), 32'd0);
        end
        check("wrap free-run", 32'(count_w), 32'd4);

        // Down from 1: WRAP 1,0,11,10; SAT holds 0.
        en = 1'b0; up_dn = 1'b0; load = 1'b1; load_val = 4'd1; step();
        both("dn load1", 1, 1, 0, 0, 0, 0);
        load = 1'b0; en = 1'b1; step();
        both("dn 0", 0, 0, 1, 1, 0, 0);
        step(); both("dn roll", 11, 0, 0, 1, 1, 0);
        step(); both("dn 10", 10, 0, 0, 1, 0, 0);

        // Priority and clamp.
        up_dn = 1'b1; load = 1'b1; load_val = 4'd15; step();
        both("clamp 15", 11, 11, 1, 1, 0, 0);
        load_val = 4'd3; step();
        both("load over en", 3, 3, 0, 0, 0, 0);
        clr = 1'b1; load_val = 4'd5; step();
        both("clr over load", 0, 0, 0, 0, 0, 0);
        clr = 1'b0; load = 1'b0; step();
        both("count after clr", 1, 1, 0, 0, 0, 0);
        en = 1'b0; step();
        both("hold", 1, 1, 0, 0, 0, 0);
        clr = 1'b1; step();
        both("clr alone", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
